// File: rtl/control_muestreo.sv
// control_muestreo: per-sample SPI ADC/DAC frame sequencer with datolisto/resultadolisto handshake
module control_muestreo #(
  parameter int N_BITS   = 12,
  parameter int FRAME    = 16,
  parameter int DIV_SCLK = 4,
  parameter int FS_DIV   = 2267,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_sdata,
  output logic              sclk,
  output logic              cs_n,
  output logic              dac_sdata,
  output logic [N_BITS-1:0] muestra,
  output logic              datolisto,
  input  logic              resultadolisto,
  input  logic [N_BITS-1:0] resultado,
  output logic              error_timeout,
  output logic              sobrecarga
);
  localparam int TW = $clog2(FS_DIV);
  localparam int PW = $clog2(2*DIV_SCLK);
  localparam int BW = $clog2(FRAME);
  localparam int WW = $clog2(TIMEOUT+1);
  typedef enum logic [1:0] {ESPERA, TRAMA, ENTREGA, CALCULO} state_t;
  state_t state_q;
  logic [TW-1:0] tick_q;
  logic [PW-1:0] ph_q;
  logic [BW-1:0] bit_q;
  logic [WW-1:0] wait_q, wait_d;
  logic [FRAME-1:0] dsh_q, word_d;
  logic [N_BITS-1:0] ash_q, hold_q;
  logic tick_d;
  always_comb begin
    tick_d = tick_q == TW'(FS_DIV-1);
    word_d = FRAME'(hold_q);
    wait_d = wait_q + WW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ESPERA;
      tick_q <= '0;
      ph_q <= '0;
      bit_q <= '0;
      wait_q <= '0;
      dsh_q <= '0;
      ash_q <= '0;
      hold_q <= {1'b1, {(N_BITS-1){1'b0}}};
      sclk <= 1'b1;
      cs_n <= 1'b1;
      dac_sdata <= 1'b0;
      muestra <= '0;
      datolisto <= 1'b0;
      error_timeout <= 1'b0;
      sobrecarga <= 1'b0;
    end else begin
      tick_q <= tick_d ? '0 : tick_q + TW'(1);
      datolisto <= 1'b0;
      if (tick_d && state_q != ESPERA) sobrecarga <= 1'b1;
      case (state_q)
        ESPERA: if (tick_d) begin
          state_q <= TRAMA;
          cs_n <= 1'b0;
          sclk <= 1'b0;
          ph_q <= '0;
          bit_q <= '0;
          dac_sdata <= word_d[FRAME-1];
          dsh_q <= {word_d[FRAME-2:0], 1'b0};
        end
        TRAMA: begin
          if (ph_q == PW'(DIV_SCLK-1)) begin
            ash_q <= {ash_q[N_BITS-2:0], adc_sdata};
            sclk <= 1'b1;
          end
          if (ph_q != PW'(2*DIV_SCLK-1)) ph_q <= ph_q + PW'(1);
          else if (bit_q == BW'(FRAME-1)) begin
            cs_n <= 1'b1;
            sclk <= 1'b1;
            state_q <= ENTREGA;
          end else begin
            ph_q <= '0;
            bit_q <= bit_q + BW'(1);
            sclk <= 1'b0;
            dac_sdata <= dsh_q[FRAME-1];
            dsh_q <= {dsh_q[FRAME-2:0], 1'b0};
          end
        end
        ENTREGA: begin
          muestra <= {~ash_q[N_BITS-1], ash_q[N_BITS-2:0]};
          datolisto <= 1'b1;
          wait_q <= '0;
          state_q <= CALCULO;
        end
        CALCULO: if (resultadolisto) begin
          hold_q <= {~resultado[N_BITS-1], resultado[N_BITS-2:0]};
          state_q <= ESPERA;
        end else begin
          wait_q <= wait_d;
          if (wait_d == WW'(TIMEOUT)) begin
            error_timeout <= 1'b1;
            state_q <= ESPERA;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_control_muestreo.sv
// tb_control_muestreo: randomized bench with a timeline model of frames, handshake and flags
module tb_control_muestreo;
  localparam int NB = 12, FR = 16, DV = 2, FS = 100, TO = 16, FS2 = 60, FL = 2*DV*FR;
  localparam int BIG = 1000000;
  logic clk = 0, reset = 1, adc_sdata = 0, resultadolisto = 0;
  logic [NB-1:0] resultado = '0;
  logic sclk, cs_n, dac_sdata, datolisto, error_timeout, sobrecarga;
  logic [NB-1:0] muestra;
  logic reset2 = 1;
  logic sclk2, cs2, dac2, dl2, to2, ov2;
  logic [NB-1:0] mu2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  control_muestreo #(.N_BITS(NB), .FRAME(FR), .DIV_SCLK(DV), .FS_DIV(FS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .adc_sdata(adc_sdata), .sclk(sclk), .cs_n(cs_n), .dac_sdata(dac_sdata),
    .muestra(muestra), .datolisto(datolisto), .resultadolisto(resultadolisto), .resultado(resultado),
    .error_timeout(error_timeout), .sobrecarga(sobrecarga));
  control_muestreo #(.N_BITS(NB), .FRAME(FR), .DIV_SCLK(DV), .FS_DIV(FS2), .TIMEOUT(TO)) dut2 (
    .clk(clk), .reset(reset2), .adc_sdata(1'b1), .sclk(sclk2), .cs_n(cs2), .dac_sdata(dac2),
    .muestra(mu2), .datolisto(dl2), .resultadolisto(1'b0), .resultado(12'h000),
    .error_timeout(to2), .sobrecarga(ov2));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  int c, fs, t0, ret, d, n, frames, run, last_dl, to_delta;
  logic [FR-1:0] adc_w, dac_w;
  logic [NB-1:0] res, exp_hold, exp_mu;
  logic exp_to, exp_ov;
  logic [FR-1:0] dacw[$];
  int lens[$];
  logic [NB-1:0] mus[$];
  task automatic mreset();
    c = 0; fs = -BIG; t0 = -BIG; ret = 0; d = 0;
    exp_hold = 12'h800; exp_mu = '0; exp_to = 0; exp_ov = 0;
  endtask
  // one clock cycle: compare against the timeline model, then drive inputs and advance the model
  task automatic step(input logic r);
    int p, b;
    logic infr;
    @(negedge clk);
    n++;
    p = c - fs;
    infr = p >= 0 && p < FL;
    b = infr ? p / (2*DV) : 0;
    if (c == t0) exp_mu = {~adc_w[NB-1], adc_w[NB-2:0]};
    if (c == t0 + TO && d >= TO) exp_to = 1;
    chk("cs_n", cs_n, !infr);
    chk("sclk", sclk, infr ? ((p % (2*DV)) >= DV) : 1'b1);
    if (infr) chk("dac_sdata", dac_sdata, dac_w[FR-1-b]);
    else if (fs < 0) chk("dac_idle", dac_sdata, 0);
    chk("datolisto", datolisto, c == t0);
    chk("muestra", muestra, exp_mu);
    chk("error_timeout", error_timeout, exp_to);
    chk("sobrecarga", sobrecarga, exp_ov);
    if (datolisto) begin mus.push_back(muestra); last_dl = n; end
    if (error_timeout && to_delta < 0) to_delta = n - last_dl;
    if (!cs_n) run++;
    else if (run > 0) begin lens.push_back(run); run = 0; end
    reset = r;
    adc_sdata = infr ? adc_w[FR-1-b] : 1'($urandom);
    if (c == t0 + d) begin
      resultadolisto = 1;
      resultado = res;
      if (d < TO) exp_hold = {~res[NB-1], res[NB-2:0]};
    end else begin
      resultadolisto = !(c >= t0 && c < ret) && ($urandom_range(0, 7) == 0);
      resultado = NB'($urandom);
    end
    if (r) mreset();
    else begin
      if (c % FS == FS - 1) begin
        if (c >= ret) begin
          fs = c + 1;
          t0 = fs + FL + 1;
          dac_w = FR'(exp_hold);
          adc_w = FR'($urandom);
          res = NB'($urandom);
          if (frames == 0) begin adc_w = 16'h0ABC; d = 7; res = 12'hF00; end
          else if (frames == 1) d = 25;
          else if (frames == 2) d = 3;
          else d = ($urandom_range(0, 3) == 0) ? $urandom_range(TO, TO + 6) : $urandom_range(0, TO - 1);
          ret = d < TO ? t0 + d + 1 : t0 + TO;
          frames++;
        end else exp_ov = 1;
      end
      c++;
    end
  endtask
  logic [FR-1:0] mw;
  int nb = 0;
  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      if (nb == FR) dacw.push_back(mw);
      nb = 0;
    end else begin
      mw = {mw[FR-2:0], dac_sdata};
      nb++;
    end
  end
  int c2 = 0, fall2 = 0, nfr2 = 0, nr2 = 0;
  logic pcs2 = 1, ps2 = 1;
  initial #22 reset2 = 0;
  always @(negedge clk) begin
    if (reset2) c2 = 0;
    else begin
      c2++;
      chk("sobrecarga2", ov2, c2 >= 2*FS2);
      if (!cs2 && pcs2) begin chk("frame2_start", c2 % (2*FS2), FS2); fall2 = c2; nfr2++; nr2 = 0; end
      if (!cs2 && sclk2 && !ps2) nr2++;
      if (cs2 && !pcs2) begin chk("frame2_len", c2 - fall2, FL); chk("frame2_sclk", nr2, FR); end
      if (dl2) begin chk("muestra2", mu2, 12'h7FF); chk("datolisto2_delay", c2 - fall2, FL + 1); end
    end
    pcs2 = cs2;
    ps2 = sclk2;
  end
  initial begin
    int k;
    mreset();
    n = 0; frames = 0; run = 0; last_dl = 0; to_delta = -1;
    step(1);
    step(1);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_dac", dac_sdata, 0);
    chk("rst_datolisto", datolisto, 0);
    chk("rst_muestra", muestra, 0);
    chk("rst_flags", {error_timeout, sobrecarga}, 0);
    repeat (420) step(0);
    chk("dac_words", dacw.size() >= 3, 1);
    chk("dac_word0", dacw[0], 16'h0800);
    chk("dac_word1", dacw[1], 16'h0700);
    chk("dac_word2", dacw[2], 16'h0700);
    chk("muestra0", mus[0], 12'h2BC);
    chk("frame_len0", lens[0], 64);
    chk("timeout_delay", to_delta, 16);
    repeat (3000) step(0);
    for (int i = 0; i < 200 && c - fs != 20; i++) step(0);
    chk("midframe_reached", c - fs, 20);
    k = dacw.size();
    step(1);
    step(0);
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 1);
    repeat (200) step(0);
    chk("dac_after_reset_cnt", dacw.size() > k, 1);
    chk("dac_word_after_reset", dacw[k], 16'h0800);
    chk("dut2_frames", nfr2 >= 10, 1);
    chk("timeout2", to2, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_muestreo.md
Name: control_muestreo

Overview:
- Sample-rate sequencer for the audio equalizer; it drives the `datolisto`/`resultadolisto` handshake of the arithmetic control unit from the opposite side.
- Once per sample period it runs one full-duplex SPI frame. The frame reads x(k) from the serial ADC and writes the previous result y(k-1) to the serial DAC.
- After the frame it presents x(k) to the arithmetic unit with a one-cycle `datolisto` pulse. It then waits for `resultadolisto` and latches y(k) for the next DAC frame.

Parameters:
- N_BITS, 12, sample width (ADC, DAC, arithmetic path).
- FRAME, 16, SCLK periods per SPI frame; the N_BITS data bits occupy the last N_BITS positions.
- DIV_SCLK, 4, clk cycles per SCLK half-period.
- FS_DIV, 2267, clk cycles per sample period (100 MHz / 44.1 kHz).
- TIMEOUT, 16, max clk cycles to wait for `resultadolisto`.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset
- adc_sdata  in  1  serial data from ADC, MSB first
- sclk  out  1  SPI clock, shared by ADC and DAC; idles high
- cs_n  out  1  SPI chip select, shared; active low
- dac_sdata  out  1  serial data to DAC, MSB first
- muestra  out  N_BITS  x(k), two's complement, valid while `datolisto`=1 and held until the next `datolisto`
- datolisto  out  1  one-cycle pulse to the arithmetic unit
- resultadolisto  in  1  result-valid pulse from the arithmetic unit
- resultado  in  N_BITS  y(k), two's complement, sampled when `resultadolisto`=1 in CALCULO
- error_timeout  out  1  sticky: a `resultadolisto` was missed
- sobrecarga  out  1  sticky: a sample tick arrived while busy

Behaviour:
- Reset: synchronous, active-high, priority over everything.
  - `sclk`=1, `cs_n`=1, `dac_sdata`=0, `datolisto`=0, `muestra`=0, flags=0.
  - DAC hold register = 12'h800 (midscale), tick counter=0, state=ESPERA.
  - Reset mid-frame aborts the frame: the outputs above hold from the next edge; no `datolisto` is issued.
- Tick counter:
  - Free-running over 0..FS_DIV-1; `tick`=1 when count=FS_DIV-1.
  - `tick` outside ESPERA is dropped and sets `sobrecarga`.
- States:
  - ESPERA: on `tick`, go to TRAMA. `cs_n` falls on that edge; bit counter=0; DAC shift register loads {(FRAME-N_BITS) zeros, hold register}.
  - TRAMA: each bit is a low phase of DIV_SCLK clks followed by a high phase of DIV_SCLK clks.
    - `dac_sdata` updates at the first clk of each low phase.
    - `adc_sdata` is shifted in on the last clk of each low phase.
    - After the high phase of bit FRAME-1, `cs_n` rises and the state goes to ENTREGA.
    - Frame length with `cs_n` low = 2*DIV_SCLK*FRAME clks (128 at default).
  - ENTREGA: `muestra` = low N_BITS of the ADC shift register with the MSB inverted (offset binary to two's complement). `datolisto`=1 for exactly this one cycle; go to CALCULO and clear the wait counter.
  - CALCULO:
    - If `resultadolisto`=1: the hold register takes `resultado` with the MSB inverted (two's complement to offset binary); go to ESPERA.
    - Otherwise increment the wait counter. When the counter reaches TIMEOUT: set `error_timeout`, keep the hold register unchanged, go to ESPERA.
    - `resultadolisto` asserted in the same cycle the counter reaches TIMEOUT counts as a valid capture, not a timeout.
- `resultadolisto` in any state other than CALCULO is ignored.
- Pipeline: DAC output lags the ADC input by one sample period.
- Sticky flags are cleared only by reset.
- Legal configuration: FS_DIV > 2*DIV_SCLK*FRAME + TIMEOUT + 3. Violating it is not illegal in RTL; the block drops ticks and sets `sobrecarga`.

Test Plan (simulation setting: DIV_SCLK=2, FS_DIV=100, TIMEOUT=16 unless noted):
- ADC model sends 16'h0ABC -> one `datolisto` pulse 1 clk after `cs_n` rises; `muestra`=12'h2BC at that pulse; `cs_n` low exactly 64 clks.
- Arithmetic-unit model answers 7 clks after `datolisto` with `resultado`=12'hF00 -> next frame shifts 16'h0700 on `dac_sdata`. The first frame after reset shifts 16'h0800.
- No `resultadolisto` -> `error_timeout`=1 exactly 16 clks after `datolisto`; the next DAC frame repeats the previous word; the flag stays set.
- Run with FS_DIV=60 (shorter than one frame) -> `sobrecarga`=1; frames start only on every other tick; no corrupted frame.
- Reset asserted in the middle of TRAMA -> next edge `cs_n`=1, `sclk`=1; no `datolisto`; the next frame starts on the first tick after release; DAC word 16'h0800.
- `resultadolisto` pulsed during ESPERA and during TRAMA -> hold register unchanged, no state change.
